cal_pulse_gen_multi: RTL and testbench

//  Multi-channel calibration injection generator in the EOC command path.
//  One accepted Cal command drives CalEdge/CalAux on a masked subset of
//  N_CH channels. Edge is a step, or a burst of pulses with programmable

---
 rtl/cal_pulse_gen_multi.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_cal_pulse_gen_multi.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cal_pulse_gen_multi.sv
// ---------------------------------------------------------------------------
// cal_pulse_gen_multi
//
// Multi-channel calibration injection generator. One accepted Cal command
// drives cal_edge_o / cal_aux_o on the subset of channels selected by the
// latched channel mask. The edge is either a held step or a burst of pulses
// with programmable delay, width, gap and repeat count. The aux level is
// applied once per command after its own delay.
//
// Ports
//   clk            in   1      160 MHz clock
//   reset_i        in   1      active-high reset, asynchronous assert
//   gen_cal_i      in   1      one-cycle start strobe
//   abort_i        in   1      cancel the running sequence
//   ch_mask_i      in   N_CH   channels driven by this command (1 = drive)
//   edge_mode_i    in   1      0 = step, 1 = pulse / burst
//   edge_dly_i     in   DLY_W  edge delay in 40 MHz units (x4 clk cycles)
//   edge_width_i   in   WID_W  pulse high time = edge_width_i + 1 cycles
//   repeat_cnt_i   in   REP_W  burst length = repeat_cnt_i + 1 pulses
//   repeat_gap_i   in   GAP_W  low time between pulses = repeat_gap_i + 1
//   aux_mode_i     in   1      level applied to cal_aux_o
//   aux_dly_i      in   AUX_W  aux delay in clk cycles
//   cal_edge_o     out  N_CH   per-channel edge signal (registered)
//   cal_aux_o      out  N_CH   per-channel aux signal (registered)
//   busy_o         out  1      sequence in progress
//   done_o         out  1      one-cycle strobe on normal completion
//   rejected_o     out  1      one-cycle strobe: gen_cal_i was dropped
//
// Timing, relative to the accept edge (the clock edge sampling gen_cal_i):
//   first edge change at edge_dly*4 + 2, aux applied at aux_dly + 2.
//   The cycle right after acceptance is an arming cycle in which the freshly
//   loaded counters hold; counting starts the cycle after that.
// ---------------------------------------------------------------------------
module cal_pulse_gen_multi #(
    parameter int N_CH  = 4,
    parameter int DLY_W = 3,
    parameter int WID_W = 6,
    parameter int AUX_W = 5,
    parameter int REP_W = 4,
    parameter int GAP_W = 6
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic             gen_cal_i,
    input  logic             abort_i,
    input  logic [N_CH-1:0]  ch_mask_i,
    input  logic             edge_mode_i,
    input  logic [DLY_W-1:0] edge_dly_i,
    input  logic [WID_W-1:0] edge_width_i,
    input  logic [REP_W-1:0] repeat_cnt_i,
    input  logic [GAP_W-1:0] repeat_gap_i,
    input  logic             aux_mode_i,
    input  logic [AUX_W-1:0] aux_dly_i,
    output logic [N_CH-1:0]  cal_edge_o,
    output logic [N_CH-1:0]  cal_aux_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             rejected_o
);

    localparam int DCNT_W = DLY_W + 2;

    localparam logic [DCNT_W-1:0] DCNT_ONE = 1;
    localparam logic [WID_W-1:0]  WID_ONE  = 1;
    localparam logic [GAP_W-1:0]  GAP_ONE  = 1;
    localparam logic [REP_W-1:0]  REP_ONE  = 1;
    localparam logic [AUX_W-1:0]  AUX_ONE  = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_HIGH  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // Reset synchronizer: assertion propagates immediately, release is
    // aligned to clk two edges after reset_i drops.
    logic [1:0] rst_sync_q;
    logic       core_rst;

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b0};
        end
    end

    assign core_rst = rst_sync_q[1];

    state_t             state_q, state_d;
    logic               arm_q, arm_d;
    logic [DCNT_W-1:0]  dly_cnt_q, dly_cnt_d;
    logic [WID_W-1:0]   wid_cnt_q, wid_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [REP_W-1:0]   rep_cnt_q, rep_cnt_d;
    logic [AUX_W-1:0]   aux_cnt_q, aux_cnt_d;
    logic               aux_pend_q, aux_pend_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               rejected_q, rejected_d;

    // Configuration latched at acceptance
    logic [N_CH-1:0]    mask_q, mask_d;
    logic               mode_q, mode_d;
    logic [WID_W-1:0]   width_q, width_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               aux_mode_q, aux_mode_d;

    logic [N_CH-1:0]    cal_edge_q, cal_edge_d;
    logic [N_CH-1:0]    cal_aux_q, cal_aux_d;

    logic               accept;
    logic               reject;
    logic               abort_run;
    logic               edge_set;
    logic               edge_clr;
    logic               aux_set;
    logic [N_CH-1:0]    edge_mask;

    assign accept    = gen_cal_i && !busy_q && !abort_i;
    assign reject    = gen_cal_i && (busy_q || abort_i);
    assign abort_run = abort_i && busy_q;

    // The clear at acceptance must use the incoming mask, since mask_q still
    // holds the previous command's channels in that cycle.
    assign edge_mask = accept ? ch_mask_i : mask_q;

    always_comb begin
        state_d    = state_q;
        arm_d      = arm_q;
        dly_cnt_d  = dly_cnt_q;
        wid_cnt_d  = wid_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        aux_cnt_d  = aux_cnt_q;
        aux_pend_d = aux_pend_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        rejected_d = reject;
        mask_d     = mask_q;
        mode_d     = mode_q;
        width_d    = width_q;
        gap_d      = gap_q;
        aux_mode_d = aux_mode_q;
        edge_set   = 1'b0;
        edge_clr   = 1'b0;
        aux_set    = 1'b0;

        if (abort_run) begin
            // Abort wins over everything else while a sequence is running
            state_d    = ST_IDLE;
            arm_d      = 1'b0;
            aux_pend_d = 1'b0;
            busy_d     = 1'b0;
            dly_cnt_d  = '0;
            wid_cnt_d  = '0;
            gap_cnt_d  = '0;
            rep_cnt_d  = '0;
            aux_cnt_d  = '0;
            edge_clr   = 1'b1;
        end else if (accept) begin
            mask_d     = ch_mask_i;
            mode_d     = edge_mode_i;
            width_d    = edge_width_i;
            gap_d      = repeat_gap_i;
            aux_mode_d = aux_mode_i;
            dly_cnt_d  = {edge_dly_i, 2'b00};
            rep_cnt_d  = repeat_cnt_i;
            aux_cnt_d  = aux_dly_i;
            wid_cnt_d  = '0;
            gap_cnt_d  = '0;
            aux_pend_d = 1'b1;
            arm_d      = 1'b1;
            busy_d     = 1'b1;
            state_d    = ST_DELAY;
            edge_clr   = 1'b1;
        end else if (arm_q) begin
            arm_d = 1'b0;
        end else begin
            if (aux_pend_q) begin
                if (aux_cnt_q != '0) begin
                    aux_cnt_d = aux_cnt_q - AUX_ONE;
                end else begin
                    aux_set    = 1'b1;
                    aux_pend_d = 1'b0;
                end
            end

            case (state_q)
                ST_DELAY: begin
                    if (dly_cnt_q != '0) begin
                        dly_cnt_d = dly_cnt_q - DCNT_ONE;
                    end else begin
                        edge_set = 1'b1;
                        if (mode_q) begin
                            wid_cnt_d = width_q;
                            state_d   = ST_HIGH;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_HIGH: begin
                    if (wid_cnt_q != '0) begin
                        wid_cnt_d = wid_cnt_q - WID_ONE;
                    end else begin
                        edge_clr = 1'b1;
                        if (rep_cnt_q != '0) begin
                            rep_cnt_d = rep_cnt_q - REP_ONE;
                            gap_cnt_d = gap_q;
                            state_d   = ST_GAP;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q != '0) begin
                        gap_cnt_d = gap_cnt_q - GAP_ONE;
                    end else begin
                        edge_set  = 1'b1;
                        wid_cnt_d = width_q;
                        state_d   = ST_HIGH;
                    end
                end
                ST_IDLE: begin
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            // Completion needs both the edge sequence and the aux update
            if (busy_q && (state_d == ST_IDLE) && !aux_pend_d) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // Per-channel output registers; unselected channels keep their value
    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            assign cal_edge_d[gi] = !edge_mask[gi] ? cal_edge_q[gi] :
                                    edge_clr       ? 1'b0 :
                                    edge_set       ? 1'b1 : cal_edge_q[gi];
            assign cal_aux_d[gi]  = (mask_q[gi] && aux_set) ? aux_mode_q
                                                            : cal_aux_q[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge core_rst) begin
        if (core_rst) begin
            state_q    <= ST_IDLE;
            arm_q      <= 1'b0;
            dly_cnt_q  <= '0;
            wid_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            rep_cnt_q  <= '0;
            aux_cnt_q  <= '0;
            aux_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rejected_q <= 1'b0;
            mask_q     <= '0;
            mode_q     <= 1'b0;
            width_q    <= '0;
            gap_q      <= '0;
            aux_mode_q <= 1'b0;
            cal_edge_q <= '0;
            cal_aux_q  <= '0;
        end else begin
            state_q    <= state_d;
            arm_q      <= arm_d;
            dly_cnt_q  <= dly_cnt_d;
            wid_cnt_q  <= wid_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
            aux_cnt_q  <= aux_cnt_d;
            aux_pend_q <= aux_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rejected_q <= rejected_d;
            mask_q     <= mask_d;
            mode_q     <= mode_d;
            width_q    <= width_d;
            gap_q      <= gap_d;
            aux_mode_q <= aux_mode_d;
            cal_edge_q <= cal_edge_d;
            cal_aux_q  <= cal_aux_d;
        end
    end

    assign cal_edge_o = cal_edge_q;
    assign cal_aux_o  = cal_aux_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign rejected_o = rejected_q;

endmodule

// File: tb/tb_cal_pulse_gen_multi.sv
// Scoreboard bench for cal_pulse_gen_multi. Stimulus pushes expected output
// values tagged with the cycle at which they must be visible; the monitor
// samples on the falling edge and compares every entry due in that cycle.
module tb_cal_pulse_gen_multi;

    localparam int SIG_EDGE = 0;
    localparam int SIG_AUX  = 1;
    localparam int SIG_BUSY = 2;
    localparam int SIG_DONE = 3;
    localparam int SIG_REJ  = 4;

    logic       clk;
    logic       reset_i;
    logic       gen_cal_i;
    logic       abort_i;
    logic [3:0] ch_mask_i;
    logic       edge_mode_i;
    logic [2:0] edge_dly_i;
    logic [5:0] edge_width_i;
    logic [3:0] repeat_cnt_i;
    logic [5:0] repeat_gap_i;
    logic       aux_mode_i;
    logic [4:0] aux_dly_i;
    logic [3:0] cal_edge_o;
    logic [3:0] cal_aux_o;
    logic       busy_o;
    logic       done_o;
    logic       rejected_o;

    cal_pulse_gen_multi dut (
        .clk          (clk),
        .reset_i      (reset_i),
        .gen_cal_i    (gen_cal_i),
        .abort_i      (abort_i),
        .ch_mask_i    (ch_mask_i),
        .edge_mode_i  (edge_mode_i),
        .edge_dly_i   (edge_dly_i),
        .edge_width_i (edge_width_i),
        .repeat_cnt_i (repeat_cnt_i),
        .repeat_gap_i (repeat_gap_i),
        .aux_mode_i   (aux_mode_i),
        .aux_dly_i    (aux_dly_i),
        .cal_edge_o   (cal_edge_o),
        .cal_aux_o    (cal_aux_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .rejected_o   (rejected_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc = number of rising edges seen so far
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        int         sig;
        logic [3:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic string sig_name(input int s);
        case (s)
            SIG_EDGE: return "cal_edge";
            SIG_AUX:  return "cal_aux";
            SIG_BUSY: return "busy";
            SIG_DONE: return "done";
            default:  return "rejected";
        endcase
    endfunction

    task automatic push(input int c, input int s, input logic [3:0] v);
        exp_t e;
        e.cyc = c;
        e.sig = s;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic push_range(input int c0, input int c1, input int s, input logic [3:0] v);
        for (int k = c0; k <= c1; k++) push(k, s, v);
    endtask

    // Expected edge waveform of a burst: n pulses of w+1 high, g+1 low,
    // first rise at cycle 'first'; unselected channels show 'other'.
    task automatic push_burst(input int t0, input int first, input int w, input int g,
                              input int n, input logic [3:0] mask, input logic [3:0] other,
                              input int last);
        for (int k = t0 + 1; k <= last; k++) begin
            int   rel;
            logic on;
            rel = k - first;
            on  = 1'b0;
            if (rel >= 0 && rel < n * (w + g + 2) && (rel % (w + g + 2)) <= w) on = 1'b1;
            push(k, SIG_EDGE, on ? (mask | other) : other);
        end
    endtask

    // Monitor: compares everything due in the current cycle
    always @(negedge clk) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].cyc == cyc) begin
                logic [3:0] act;
                case (sb_q[i].sig)
                    SIG_EDGE: act = cal_edge_o;
                    SIG_AUX:  act = cal_aux_o;
                    SIG_BUSY: act = {3'b000, busy_o};
                    SIG_DONE: act = {3'b000, done_o};
                    default:  act = {3'b000, rejected_o};
                endcase
                n_checks++;
                if (act !== sb_q[i].val) begin
                    $display("FAIL %s @cyc %0d: got %b expected %b",
                             sig_name(sb_q[i].sig), cyc, act, sb_q[i].val);
                end else begin
                    n_pass++;
                end
                sb_q.delete(i);
            end
        end
    end

    // Advance to the falling edge where cyc == c; strobes last one cycle
    task automatic run_to(input int c);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            gen_cal_i = 1'b0;
            abort_i   = 1'b0;
            guard++;
        end while (cyc < c && guard < 2000);
    endtask

    task automatic issue(input logic [3:0] mask, input logic mode, input logic [2:0] dly,
                         input logic [5:0] wid, input logic [3:0] rep, input logic [5:0] gap,
                         input logic amode, input logic [4:0] adly, output int t0);
        @(negedge clk);
        ch_mask_i    = mask;
        edge_mode_i  = mode;
        edge_dly_i   = dly;
        edge_width_i = wid;
        repeat_cnt_i = rep;
        repeat_gap_i = gap;
        aux_mode_i   = amode;
        aux_dly_i    = adly;
        gen_cal_i    = 1'b1;
        t0           = cyc + 1;
        $display("cmd @%0d mask=%b mode=%0d dly=%0d wid=%0d rep=%0d gap=%0d aux=%0d dly %0d",
                 t0, mask, mode, dly, wid, rep, gap, amode, adly);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int t0;
        int tr;

        reset_i      = 1'b1;
        gen_cal_i    = 1'b0;
        abort_i      = 1'b0;
        ch_mask_i    = '0;
        edge_mode_i  = 1'b0;
        edge_dly_i   = '0;
        edge_width_i = '0;
        repeat_cnt_i = '0;
        repeat_gap_i = '0;
        aux_mode_i   = 1'b0;
        aux_dly_i    = '0;

        // Reset state
        push(2, SIG_EDGE, 4'b0000);
        push(2, SIG_AUX,  4'b0000);
        push(2, SIG_BUSY, 4'b0000);
        push(2, SIG_DONE, 4'b0000);
        push(2, SIG_REJ,  4'b0000);
        run_to(4);

        n_checks++;
        if (cal_edge_o !== 4'b0000 || cal_aux_o !== 4'b0000) begin
            $display("FAIL reset outputs @cyc %0d: got edge %b aux %b expected 0000 0000",
                     cyc, cal_edge_o, cal_aux_o);
        end else begin
            n_pass++;
        end
        n_checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || rejected_o !== 1'b0) begin
            $display("FAIL reset status @cyc %0d: got busy %b done %b rej %b expected 0 0 0",
                     cyc, busy_o, done_o, rejected_o);
        end else begin
            n_pass++;
        end

        reset_i = 1'b0;
        run_to(8);

        // 1: step on 0101, dly 2, aux dly 3
        issue(4'b0101, 1'b0, 3'd2, 6'd0, 4'd0, 6'd0, 1'b1, 5'd3, t0);
        push(t0, SIG_BUSY, 4'b0001);
        push(t0, SIG_REJ, 4'b0000);
        push(t0 + 1, SIG_EDGE, 4'b0000);
        push(t0 + 9, SIG_EDGE, 4'b0000);
        push(t0 + 10, SIG_EDGE, 4'b0101);
        push(t0 + 16, SIG_EDGE, 4'b0101);
        push(t0 + 4, SIG_AUX, 4'b0000);
        push(t0 + 5, SIG_AUX, 4'b0101);
        push(t0 + 9, SIG_DONE, 4'b0000);
        push(t0 + 10, SIG_DONE, 4'b0001);
        push(t0 + 11, SIG_DONE, 4'b0000);
        push(t0 + 9, SIG_BUSY, 4'b0001);
        push(t0 + 10, SIG_BUSY, 4'b0000);
        run_to(t0 + 18);

        // 2: burst on 0011 (ch2 keeps its held step), 3 pulses 4 high / 2 low
        issue(4'b0011, 1'b1, 3'd1, 6'd3, 4'd2, 6'd1, 1'b0, 5'd4, t0);
        push_burst(t0, t0 + 6, 3, 1, 3, 4'b0011, 4'b0100, t0 + 26);
        push(t0 + 5, SIG_AUX, 4'b0101);
        push(t0 + 6, SIG_AUX, 4'b0100);
        push(t0 + 21, SIG_BUSY, 4'b0001);
        push(t0 + 22, SIG_BUSY, 4'b0000);
        push(t0 + 21, SIG_DONE, 4'b0000);
        push(t0 + 22, SIG_DONE, 4'b0001);
        push(t0 + 23, SIG_DONE, 4'b0000);
        run_to(t0 + 28);

        // 3: same burst, a second GenCal mid-sequence is rejected
        issue(4'b0011, 1'b1, 3'd1, 6'd3, 4'd2, 6'd1, 1'b1, 5'd4, t0);
        push_burst(t0, t0 + 6, 3, 1, 3, 4'b0011, 4'b0100, t0 + 26);
        push(t0 + 5, SIG_AUX, 4'b0100);
        push(t0 + 6, SIG_AUX, 4'b0111);
        push(t0 + 21, SIG_BUSY, 4'b0001);
        push(t0 + 22, SIG_BUSY, 4'b0000);
        push(t0 + 22, SIG_DONE, 4'b0001);
        push(t0 + 7, SIG_REJ, 4'b0000);
        push(t0 + 8, SIG_REJ, 4'b0001);
        push(t0 + 9, SIG_REJ, 4'b0000);
        run_to(t0 + 6);
        issue(4'b1111, 1'b0, 3'd0, 6'd0, 4'd0, 6'd0, 1'b0, 5'd0, tr);
        run_to(t0 + 28);

        // 4: abort during the high phase of pulse 2
        issue(4'b0011, 1'b1, 3'd1, 6'd3, 4'd2, 6'd1, 1'b0, 5'd4, t0);
        push_burst(t0, t0 + 6, 3, 1, 3, 4'b0011, 4'b0100, t0 + 12);
        push_range(t0 + 13, t0 + 26, SIG_EDGE, 4'b0100);
        push(t0 + 6, SIG_AUX, 4'b0100);
        push(t0 + 12, SIG_BUSY, 4'b0001);
        push(t0 + 13, SIG_BUSY, 4'b0000);
        push_range(t0 + 6, t0 + 26, SIG_DONE, 4'b0000);
        run_to(t0 + 12);
        abort_i = 1'b1;
        run_to(t0 + 28);

        // 4b: abort in DELAY cancels the step and the pending aux;
        //     abort alone and GenCal+Abort in IDLE have no effect
        issue(4'b1000, 1'b0, 3'd7, 6'd0, 4'd0, 6'd0, 1'b1, 5'd20, t0);
        push(t0 + 3, SIG_BUSY, 4'b0001);
        push(t0 + 4, SIG_BUSY, 4'b0000);
        push_range(t0 + 22, t0 + 24, SIG_AUX, 4'b0100);
        push(t0 + 32, SIG_EDGE, 4'b0100);
        push_range(t0 + 4, t0 + 33, SIG_DONE, 4'b0000);
        push(t0 + 35, SIG_BUSY, 4'b0000);
        push(t0 + 35, SIG_EDGE, 4'b0100);
        push(t0 + 35, SIG_REJ, 4'b0000);
        push(t0 + 36, SIG_REJ, 4'b0000);
        push(t0 + 37, SIG_REJ, 4'b0001);
        push(t0 + 38, SIG_REJ, 4'b0000);
        push(t0 + 37, SIG_BUSY, 4'b0000);
        push(t0 + 38, SIG_BUSY, 4'b0000);
        push(t0 + 40, SIG_EDGE, 4'b0100);
        push(t0 + 40, SIG_AUX, 4'b0100);
        run_to(t0 + 3);
        abort_i = 1'b1;
        run_to(t0 + 34);
        abort_i = 1'b1;
        run_to(t0 + 35);
        issue(4'b1111, 1'b0, 3'd0, 6'd0, 4'd0, 6'd0, 1'b1, 5'd0, tr);
        abort_i = 1'b1;
        run_to(t0 + 42);

        // 5: minimum delays and width: 1-cycle pulse at +2, aux at +2
        issue(4'b1111, 1'b1, 3'd0, 6'd0, 4'd0, 6'd0, 1'b1, 5'd0, t0);
        push(t0 + 1, SIG_EDGE, 4'b0000);
        push(t0 + 2, SIG_EDGE, 4'b1111);
        push(t0 + 3, SIG_EDGE, 4'b0000);
        push(t0 + 1, SIG_AUX, 4'b0100);
        push(t0 + 2, SIG_AUX, 4'b1111);
        push(t0 + 2, SIG_BUSY, 4'b0001);
        push(t0 + 3, SIG_BUSY, 4'b0000);
        push(t0 + 2, SIG_DONE, 4'b0000);
        push(t0 + 3, SIG_DONE, 4'b0001);
        run_to(t0 + 6);

        n_checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            $display("FAIL idle status @cyc %0d: got busy %b done %b expected 0 0",
                     cyc, busy_o, done_o);
        end else begin
            n_pass++;
        end

        // 6: reset asserted mid-burst clears outputs without waiting for clk
        issue(4'b1111, 1'b1, 3'd0, 6'd3, 4'd3, 6'd1, 1'b0, 5'd10, t0);
        push(t0 + 5, SIG_EDGE, 4'b1111);
        push(t0 + 7, SIG_EDGE, 4'b0000);
        push(t0 + 7, SIG_AUX, 4'b1111);
        push(t0 + 8, SIG_EDGE, 4'b0000);
        push(t0 + 8, SIG_AUX, 4'b0000);
        push(t0 + 8, SIG_BUSY, 4'b0000);
        push(t0 + 9, SIG_EDGE, 4'b0000);
        push(t0 + 9, SIG_BUSY, 4'b0000);
        run_to(t0 + 7);
        @(posedge clk);
        #2;
        reset_i = 1'b1;
        run_to(t0 + 10);
        reset_i = 1'b0;
        run_to(t0 + 14);

        // 7: after reset, maximum burst of 16 one-cycle pulses on 0110
        issue(4'b0110, 1'b1, 3'd0, 6'd0, 4'd15, 6'd0, 1'b1, 5'd2, t0);
        push_burst(t0, t0 + 2, 0, 0, 16, 4'b0110, 4'b0000, t0 + 36);
        push(t0 + 3, SIG_AUX, 4'b0000);
        push(t0 + 4, SIG_AUX, 4'b0110);
        push(t0 + 32, SIG_BUSY, 4'b0001);
        push(t0 + 33, SIG_BUSY, 4'b0000);
        push(t0 + 32, SIG_DONE, 4'b0000);
        push(t0 + 33, SIG_DONE, 4'b0001);
        run_to(t0 + 38);

        // Anything still queued was never compared
        foreach (sb_q[i]) begin
            n_checks++;
            $display("FAIL %s @cyc %0d: got no sample expected %b",
                     sig_name(sb_q[i].sig), sb_q[i].cyc, sb_q[i].val);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        if (n_pass == n_checks) begin
            $display("PASS all checks");
        end else begin
            $display("FAIL summary: got %0d passing expected %0d", n_pass, n_checks);
        end
        $finish;
    end

endmodule
